// File: rtl/dpseq_pkg.sv
// Shared types and field map for the datapath sequencer: states, instruction
// classes, bit positions of the 16-bit control word and the decoded-word struct.
package dpseq_pkg;

    localparam int DP_INSTR_W = 16;
    localparam int DP_ADDR_W  = 3;
    localparam int DP_REP_W   = 2;

    localparam int CLS_HI = 15;
    localparam int CLS_LO = 14;
    localparam int OPC_BIT = 13;
    localparam int S_HI   = 12;
    localparam int S_LO   = 11;
    localparam int WR_HI  = 10;
    localparam int WR_LO  = 8;
    localparam int RDA_HI = 7;
    localparam int RDA_LO = 5;
    localparam int RDB_HI = 4;
    localparam int RDB_LO = 2;
    localparam int REP_HI = 1;
    localparam int REP_LO = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXEC,
        ST_OUTP,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        CLS_LOAD = 2'b00,
        CLS_ALU  = 2'b01,
        CLS_OUT  = 2'b10,
        CLS_NOP  = 2'b11
    } cls_e;

    typedef struct packed {
        cls_e                  cls;
        logic                  opcode;
        logic [1:0]            s;
        logic [DP_ADDR_W-1:0]  wr;
        logic [DP_ADDR_W-1:0]  rda;
        logic [DP_ADDR_W-1:0]  rdb;
        logic [DP_REP_W-1:0]   rep;
    } dpseq_instr_t;

endpackage

// File: rtl/dpseq_decode.sv
// Combinational split of a raw control word into its decoded fields.
module dpseq_decode
    import dpseq_pkg::*;
(
    input  logic [DP_INSTR_W-1:0] word,
    output dpseq_instr_t          dec
);

    always_comb begin
        dec.cls    = cls_e'(word[CLS_HI:CLS_LO]);
        dec.opcode = word[OPC_BIT];
        dec.s      = word[S_HI:S_LO];
        dec.wr     = word[WR_HI:WR_LO];
        dec.rda    = word[RDA_HI:RDA_LO];
        dec.rdb    = word[RDB_HI:RDB_LO];
        dec.rep    = word[REP_HI:REP_LO];
    end

endmodule

// File: rtl/datapath_sequencer.sv
// Instruction-driven sequencer for the regfile/ALU/shift/output datapath.
// Optional illegal-word trap enabled with `define DPSEQ_ILLEGAL_TRAP_EN.
module datapath_sequencer
    import dpseq_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 3,
    parameter int REP_W   = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               IE,
    output logic               WE,
    output logic               OE,
    output logic [1:0]         S,
    output logic [ADDR_W-1:0]  ADDR_WR,
    output logic [ADDR_W-1:0]  ADDR_RDA,
    output logic [ADDR_W-1:0]  ADDR_RDB,
    output logic               Opcode
);

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [REP_W-1:0]   cnt_q, cnt_d;
    dpseq_instr_t       in_dec, cur_dec;

    dpseq_decode u_dec_in  (.word(instr),   .dec(in_dec));
    dpseq_decode u_dec_cur (.word(instr_q), .dec(cur_dec));

`ifdef DPSEQ_ILLEGAL_TRAP_EN
    logic err_q, err_d;
    logic trap_hit;

    // Trap decisions are taken on the incoming word at accept time.
    assign trap_hit = (in_dec.cls == CLS_NOP && instr[OPC_BIT:0] != '0) ||
                      (in_dec.cls == CLS_ALU && in_dec.rep != '0 && in_dec.wr == in_dec.rdb);
    assign err_d = err_q | (state_q == ST_IDLE && instr_valid && trap_hit);
    assign err   = err_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) err_q <= 1'b0;
        else     err_q <= err_d;
    end
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        cnt_d       = cnt_q;
        instr_ready = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        IE          = 1'b0;
        WE          = 1'b0;
        OE          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
                if (instr_valid) begin
                    instr_d = instr;
                    cnt_d   = in_dec.rep;
                    case (in_dec.cls)
                        CLS_LOAD: state_d = ST_LOAD;
                        CLS_ALU:  state_d = ST_EXEC;
                        CLS_OUT:  state_d = ST_OUTP;
                        default:  state_d = ST_DONE;
                    endcase
                end
            end
            ST_LOAD: begin
                IE      = 1'b1;
                WE      = 1'b1;
                state_d = ST_DONE;
            end
            ST_EXEC: begin
                WE = 1'b1;
                // Counter holds remaining repeats after the current cycle.
                if (cnt_q == '0) state_d = ST_DONE;
                else             cnt_d   = cnt_q - REP_W'(1);
            end
            ST_OUTP: begin
                OE      = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Address/shift/opcode lines always reflect the latched word so they stay stable.
    assign S        = cur_dec.s;
    assign ADDR_WR  = cur_dec.wr;
    assign ADDR_RDA = cur_dec.rda;
    assign ADDR_RDB = cur_dec.rdb;
    assign Opcode   = cur_dec.opcode;

endmodule
